// File: rtl/uart_frame_tx_if.sv
// Byte-stream port between the row compressor and the UART frame transmitter.
// Latency: none (wires only).
// Backpressure: oAllowed-style credit via o_allowed; o_level exposes FIFO occupancy.
interface uart_frame_tx_if #(
  parameter int FifoDepth = 16
);
  logic [7:0]                 i_data;
  logic                       i_valid;
  logic                       o_allowed;
  logic                       o_tx;
  logic                       o_busy;
  logic                       o_overflow;
  logic [$clog2(FifoDepth):0] o_level;

  // Upstream side: drives bytes, observes flow control and status.
  modport master (
    output i_data, i_valid,
    input  o_allowed, o_tx, o_busy, o_overflow, o_level
  );

  // Transmitter side.
  modport slave (
    input  i_data, i_valid,
    output o_allowed, o_tx, o_busy, o_overflow, o_level
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Buffers compressor bytes in a small FIFO and serialises them as 8N1/8N2 UART frames, LSB first.
// Latency: byte strobed at edge E on an idle, empty block drives the start bit from edge E+2.
// Backpressure: o_allowed drops once fewer than two slots remain; bytes arriving with no room are dropped and flagged.
module uart_frame_tx #(
  parameter int ClkFreq   = 100000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 16,
  parameter int StopBits  = 1
) (
  input logic            CLK,
  input logic            RST,
  uart_frame_tx_if.slave bus
);
  localparam int ClksPerBit = ClkFreq / BaudRate;
  localparam int AddrW      = $clog2(FifoDepth);
  localparam int LvlW       = AddrW + 1;
  localparam int CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  localparam logic [CntW-1:0] BaudLast = CntW'(ClksPerBit - 1);
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(FifoDepth);
  localparam logic [LvlW-1:0] AllowLvl = LvlW'(FifoDepth - 2);
  localparam logic [2:0]      StopLast = 3'(StopBits - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT            state, stateNext;
  logic [CntW-1:0]  baudCnt, baudNext;
  logic [2:0]       bitIdx, bitNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             txReg;
  logic [7:0]       fifoMem [FifoDepth];
  logic [AddrW-1:0] wrPtr, rdPtr;
  logic [LvlW-1:0]  level;
  logic             overflow;
  logic             pop, push, baudWrap;

  assign baudWrap = (baudCnt == BaudLast);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = bus.i_valid && ((level < DepthLvl) || pop);

  // Frame sequencing: next state, baud/bit counters, shift register and FIFO pop.
  always_comb begin
    stateNext = state;
    baudNext  = baudWrap ? '0 : baudCnt + 1'b1;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baudNext = '0;
        bitNext  = '0;
        if (level != '0) begin
          pop       = 1'b1;
          shiftNext = fifoMem[rdPtr];
          stateNext = START;
        end
      end
      START: begin
        if (baudWrap) begin
          stateNext = DATA;
          bitNext   = '0;
        end
      end
      DATA: begin
        if (baudWrap) begin
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            bitNext   = '0;
          end else begin
            bitNext = bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baudWrap) begin
          if (bitIdx == StopLast) begin
            bitNext = '0;
            // Chain straight into the next start bit when more bytes are queued.
            if (level != '0) begin
              pop       = 1'b1;
              shiftNext = fifoMem[rdPtr];
              stateNext = START;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitNext = bitIdx + 3'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered state, counters, line driver and FIFO bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      // The line follows the current state one cycle later, so every bit keeps its full width.
      txReg    <= (state == START) ? 1'b0 : (state == DATA) ? shiftReg[0] : 1'b1;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (bus.i_valid && !push) overflow <= 1'b1;
    end
  end

  // FIFO storage; pointers alone define which entries are valid, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) fifoMem[wrPtr] <= bus.i_data;
  end

  assign bus.o_tx       = txReg;
  assign bus.o_allowed  = (level <= AllowLvl);
  assign bus.o_busy     = (state != IDLE) || (level != '0);
  assign bus.o_overflow = overflow;
  assign bus.o_level    = level;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed and randomised checks of uart_frame_tx on three configurations sharing one clock and reset.
// Latency: line is decoded by a behavioural UART receiver that samples every cycle of every bit.
// Backpressure: a model upstream honours o_allowed with one cycle of registration delay.
module tb_uart_frame_tx;
  typedef struct {
    logic [7:0] b;
    int         t;
    bit         ok;
  } rxFrameT;

  logic       CLK;
  logic       RST;
  logic [7:0] dIn [3];
  logic       vld [3];
  logic       txW [3];
  logic       busy [3];
  logic       ovf [3];
  logic       allowed [3];
  logic [4:0] lvl [3];

  int         cyc = 0;
  int         nTests = 0;
  int         nFail = 0;
  rxFrameT    rxQ [$];
  logic [7:0] expQ [$];
  logic [7:0] pkt [6] = '{8'h01, 8'h3C, 8'h50, 8'h25, 8'h80, 8'h0C};

  // A: 8 clocks/bit, depth 16, 1 stop. B: depth 4. C: 2 stop bits.
  uart_frame_tx_if #(.FifoDepth(16)) ifA ();
  uart_frame_tx_if #(.FifoDepth(4))  ifB ();
  uart_frame_tx_if #(.FifoDepth(16)) ifC ();

  uart_frame_tx #(.ClkFreq(8), .BaudRate(1), .FifoDepth(16), .StopBits(1)) dutA (.CLK(CLK), .RST(RST), .bus(ifA));
  uart_frame_tx #(.ClkFreq(8), .BaudRate(1), .FifoDepth(4),  .StopBits(1)) dutB (.CLK(CLK), .RST(RST), .bus(ifB));
  uart_frame_tx #(.ClkFreq(8), .BaudRate(1), .FifoDepth(16), .StopBits(2)) dutC (.CLK(CLK), .RST(RST), .bus(ifC));

  assign ifA.i_data = dIn[0];
  assign ifB.i_data = dIn[1];
  assign ifC.i_data = dIn[2];
  assign ifA.i_valid = vld[0];
  assign ifB.i_valid = vld[1];
  assign ifC.i_valid = vld[2];
  assign txW[0] = ifA.o_tx;
  assign txW[1] = ifB.o_tx;
  assign txW[2] = ifC.o_tx;
  assign busy[0] = ifA.o_busy;
  assign busy[1] = ifB.o_busy;
  assign busy[2] = ifC.o_busy;
  assign ovf[0] = ifA.o_overflow;
  assign ovf[1] = ifB.o_overflow;
  assign ovf[2] = ifC.o_overflow;
  assign allowed[0] = ifA.o_allowed;
  assign allowed[1] = ifB.o_allowed;
  assign allowed[2] = ifC.o_allowed;
  assign lvl[0] = ifA.o_level;
  assign lvl[1] = {2'b00, ifB.o_level};
  assign lvl[2] = ifC.o_level;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nTests++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Behavioural receiver: each bit must hold one value for all 8 cycles; start 0, stops 1.
  task automatic monitor(input int idx, input int sb);
    rxFrameT f;
    logic    v0;
    bit      abort;
    forever begin
      @(negedge CLK);
      if (RST && txW[idx] === 1'b0) begin
        f.t = cyc; f.ok = 1'b1; f.b = '0; abort = 1'b0; v0 = 1'b0;
        for (int bi = 0; bi < 9 + sb && !abort; bi++) begin
          for (int c = 0; c < 8 && !abort; c++) begin
            if (bi != 0 || c != 0) @(negedge CLK);
            if (!RST) abort = 1'b1;
            else if (c == 0) begin
              v0 = txW[idx];
              if (bi == 0 && v0 !== 1'b0) f.ok = 1'b0;
              if (bi > 8 && v0 !== 1'b1) f.ok = 1'b0;
              if (bi >= 1 && bi <= 8) f.b[bi-1] = v0;
            end else if (txW[idx] !== v0) f.ok = 1'b0;
          end
        end
        if (!abort) rxQ.push_back(f);
      end
    end
  endtask

  initial fork
    monitor(0, 1);
    monitor(1, 1);
    monitor(2, 2);
  join_none

  task automatic waitIdle(input int idx, input int bound, output int endCyc, output int peak);
    peak = int'(lvl[idx]);
    for (int k = 0; k < bound && busy[idx] !== 1'b0; k++) begin
      tick();
      if (int'(lvl[idx]) > peak) peak = int'(lvl[idx]);
    end
    endCyc = cyc;
    chk($sformatf("idle_wait_%0d", idx), busy[idx], 0);
  endtask

  // Compares decoded frames to expQ; period > 0 also checks start cycles t0 + period*i.
  task automatic checkRx(input string tag, input int t0, input int period);
    chk({tag, "_count"}, rxQ.size(), expQ.size());
    for (int i = 0; i < rxQ.size() && i < expQ.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), rxQ[i].b, expQ[i]);
      chk($sformatf("%s_frame%0d", tag, i), rxQ[i].ok, 1);
      if (period > 0) chk($sformatf("%s_start%0d", tag, i), rxQ[i].t, t0 + period * i);
    end
  endtask

  initial begin
    int         e, endCyc, peak, sent, flowBad, gap;
    bit         blocked, prevA, a;
    logic [7:0] b;

    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin dIn[i] = '0; vld[i] = 1'b0; end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx_%0d", i), txW[i], 1);
      chk($sformatf("rst_busy_%0d", i), busy[i], 0);
      chk($sformatf("rst_ovf_%0d", i), ovf[i], 0);
      chk($sformatf("rst_lvl_%0d", i), lvl[i], 0);
      chk($sformatf("rst_allowed_%0d", i), allowed[i], 1);
    end
    RST = 1'b1;
    tick();

    // Single byte 0xA5: start bit from E+2, 80-cycle frame, busy clears at E+81.
    rxQ.delete(); expQ.delete();
    dIn[0] = 8'hA5; vld[0] = 1'b1; tick(); e = cyc; vld[0] = 1'b0;
    expQ.push_back(8'hA5);
    chk("t1_lvl", lvl[0], 1);
    chk("t1_tx_e0", txW[0], 1);
    tick(); chk("t1_tx_e1", txW[0], 1);
    tick(); chk("t1_tx_e2", txW[0], 0);
    waitIdle(0, 200, endCyc, peak);
    chk("t1_busy_end", endCyc, e + 81);
    repeat (3) tick();
    chk("t1_tx_idle", txW[0], 1);
    checkRx("t1", e + 2, 80);

    // Six-byte packet on consecutive cycles: gapless frames, peak level 5.
    rxQ.delete(); expQ.delete();
    peak = 0; e = 0;
    for (int i = 0; i < 6; i++) begin
      dIn[0] = pkt[i]; vld[0] = 1'b1; expQ.push_back(pkt[i]);
      tick();
      if (i == 0) e = cyc;
      if (int'(lvl[0]) > peak) peak = int'(lvl[0]);
    end
    vld[0] = 1'b0;
    begin
      int p2;
      waitIdle(0, 600, endCyc, p2);
      if (p2 > peak) peak = p2;
    end
    chk("t2_peak", peak, 5);
    repeat (3) tick();
    checkRx("t2", e + 2, 80);

    // Flow control, depth 4: upstream strobes one cycle after seeing o_allowed.
    rxQ.delete(); expQ.delete();
    sent = 0; flowBad = 0; blocked = 1'b0; prevA = 1'b0;
    for (int k = 0; k < 3000 && sent < 12; k++) begin
      a = allowed[1];
      if (lvl[1] <= 5'd2 && !a) flowBad++;
      if (lvl[1] >= 5'd3 && a) flowBad++;
      if (lvl[1] == 5'd3 && !a) blocked = 1'b1;
      if (prevA) begin
        dIn[1] = 8'($urandom); vld[1] = 1'b1; expQ.push_back(dIn[1]); sent++;
      end else vld[1] = 1'b0;
      tick();
      prevA = a;
    end
    vld[1] = 1'b0;
    waitIdle(1, 1500, endCyc, peak);
    chk("t3_sent", sent, 12);
    chk("t3_flow_rule", flowBad, 0);
    chk("t3_blocked_at_3", blocked, 1);
    chk("t3_ovf", ovf[1], 0);
    repeat (3) tick();
    checkRx("t3", 0, 0);

    // Forced overflow, depth 4: six strobes; first byte pops at E+1, so five fit.
    rxQ.delete(); expQ.delete();
    e = 0;
    for (int i = 0; i < 6; i++) begin
      dIn[1] = 8'($urandom); vld[1] = 1'b1;
      if (i < 5) expQ.push_back(dIn[1]);
      tick();
      if (i == 0) e = cyc;
      if (i == 3) chk("t4_ovf_early", ovf[1], 0);
      if (i == 4) begin
        chk("t4_full_lvl", lvl[1], 4);
        chk("t4_full_allowed", allowed[1], 0);
        chk("t4_ovf_at_full", ovf[1], 0);
      end
    end
    vld[1] = 1'b0;
    chk("t4_ovf_set", ovf[1], 1);
    chk("t4_lvl_after_drop", lvl[1], 4);
    waitIdle(1, 600, endCyc, peak);
    chk("t4_ovf_sticky", ovf[1], 1);
    repeat (3) tick();
    checkRx("t4", e + 2, 80);

    // Reset while data bit 3 is on the line, then a fresh byte.
    rxQ.delete(); expQ.delete();
    b = 8'($urandom);
    dIn[0] = b; vld[0] = 1'b1; tick(); e = cyc; vld[0] = 1'b0;
    while (cyc < e + 35) tick();
    chk("t5_bit3", txW[0], b[3]);
    RST = 1'b0;
    tick();
    chk("t5_rst_tx", txW[0], 1);
    chk("t5_rst_lvl", lvl[0], 0);
    chk("t5_rst_busy", busy[0], 0);
    chk("t5_rst_ovf_b", ovf[1], 0);
    RST = 1'b1;
    repeat (3) tick();
    chk("t5_aborted", rxQ.size(), 0);
    b = 8'($urandom);
    dIn[0] = b; vld[0] = 1'b1; tick(); e = cyc; vld[0] = 1'b0;
    expQ.push_back(b);
    waitIdle(0, 200, endCyc, peak);
    repeat (3) tick();
    checkRx("t5", e + 2, 80);

    // Two stop bits: 0xFF then 0x00, frames 88 cycles apart with no gap.
    rxQ.delete(); expQ.delete();
    dIn[2] = 8'hFF; vld[2] = 1'b1; expQ.push_back(8'hFF); tick(); e = cyc;
    dIn[2] = 8'h00; expQ.push_back(8'h00); tick();
    vld[2] = 1'b0;
    waitIdle(2, 400, endCyc, peak);
    repeat (3) tick();
    checkRx("t6", e + 2, 88);

    // Random bytes with random short gaps.
    rxQ.delete(); expQ.delete();
    for (int i = 0; i < 8; i++) begin
      dIn[0] = 8'($urandom); vld[0] = 1'b1; expQ.push_back(dIn[0]);
      tick();
      vld[0] = 1'b0;
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick();
    end
    waitIdle(0, 1200, endCyc, peak);
    chk("t7_ovf", ovf[0], 0);
    repeat (3) tick();
    checkRx("t7", 0, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
